// File: rtl/regfile_scrub_controller_pkg.sv
// Shared register-file definitions.
// Holds the default geometry of the register file (entry count, address and
// data widths), the width of the scrub counter and the scrub controller's
// state encoding. Both the scrub controller and the register file import it,
// so the two sides always agree on geometry.
package regfile_scrub_controller_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int ADDR_W_DEF   = 4;   // clog2(NUM_REGS_DEF)
    localparam int DATA_W_DEF   = 32;
    localparam int COUNT_W      = 8;

    // SCRUB is the reset state, so every release from reset starts a full scrub.
    typedef enum logic [1:0] {
        SCRUB = 2'd0,
        DONE  = 2'd1,
        IDLE  = 2'd2
    } state_t;

endpackage : regfile_scrub_controller_pkg

// File: rtl/regfile_scrub_controller_if.sv
// Client write channel of the register-file scrub controller.
// valid/ready handshake. A transfer happens in any cycle where both
// client_wr_valid and client_wr_ready are high. The client holds valid, addr
// and data stable until the transfer happens.
//   master : client side  (drives valid/addr/data, observes ready)
//   slave  : controller   (observes valid/addr/data, drives ready)
interface regfile_scrub_controller_if
    import regfile_scrub_controller_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              client_wr_valid;
    logic              client_wr_ready;
    logic [ADDR_W-1:0] client_wr_addr;
    logic [DATA_W-1:0] client_wr_data;

    modport master (
        output client_wr_valid,
        output client_wr_addr,
        output client_wr_data,
        input  client_wr_ready
    );

    modport slave (
        input  client_wr_valid,
        input  client_wr_addr,
        input  client_wr_data,
        output client_wr_ready
    );

endinterface : regfile_scrub_controller_if

// File: rtl/regfile_scrub_controller.sv
// Register-file scrub controller.
// Drives the write port of a register file. After reset, and again on each
// scrub request, it zeroes every entry. It writes addresses 0..NUM_REGS-1 in
// ascending order, one write per cycle. While no scrub is running, it passes
// client writes through to the register file.
// Ports:
//   clk, rst            clock and reset (asynchronous, active-high)
//   scrub_req           level-sampled request to zero the whole register file
//   client (slave)      client write channel (valid/ready/addr/data)
//   write_enable/addr/data  registered write port to the register file
//   busy                high whenever the controller is not IDLE
//   scrub_done          one-cycle pulse that coincides with the last scrub write
//   scrub_count         number of completed scrubs, saturating at 255
module regfile_scrub_controller
    import regfile_scrub_controller_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scrub_req,
    regfile_scrub_controller_if.slave client,
    output logic                      write_enable,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic                      busy,
    output logic                      scrub_done,
    output logic [COUNT_W-1:0]        scrub_count
);

    // The scrub ends on an explicit compare against the last entry. It does
    // not rely on the pointer wrapping, so a NUM_REGS smaller than 2**ADDR_W
    // still stops at the right address.
    localparam logic [ADDR_W-1:0]  LAST_PTR  = ADDR_W'(NUM_REGS - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  ptr_reg, ptr_next;
    logic               write_enable_reg, write_enable_next;
    logic [ADDR_W-1:0]  write_addr_reg, write_addr_next;
    logic [DATA_W-1:0]  write_data_reg, write_data_next;
    logic [COUNT_W-1:0] scrub_count_reg, scrub_count_next;
    logic               client_ready;
    logic               client_xfer;

    assign client_ready = (state_reg == IDLE);
    assign client_xfer  = client.client_wr_valid && client_ready;

    // State register. The pointer and the output registers are updated here too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= SCRUB;
            ptr_reg          <= '0;
            write_enable_reg <= 1'b0;
            write_addr_reg   <= '0;
            write_data_reg   <= '0;
            scrub_count_reg  <= '0;
        end else begin
            state_reg        <= state_next;
            ptr_reg          <= ptr_next;
            write_enable_reg <= write_enable_next;
            write_addr_reg   <= write_addr_next;
            write_data_reg   <= write_data_next;
            scrub_count_reg  <= scrub_count_next;
        end
    end

    // Next-state logic. scrub_req is only looked at in IDLE: a request that
    // arrives during SCRUB or DONE is dropped, not queued.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            SCRUB: begin
                ptr_next = ptr_reg + ADDR_W'(1);
                if (ptr_reg == LAST_PTR) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            IDLE: begin
                if (scrub_req) begin
                    state_next = SCRUB;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = SCRUB;
                ptr_next   = '0;
            end
        endcase
    end

    // Output logic. This computes what the output registers load on the next
    // edge. In a cycle with no write, the strobe drops and addr/data keep their
    // last values. If a client transfer and scrub_req arrive together in IDLE,
    // the client write goes out first and the scrub then overwrites it.
    always_comb begin
        write_enable_next = 1'b0;
        write_addr_next   = write_addr_reg;
        write_data_next   = write_data_reg;
        scrub_count_next  = scrub_count_reg;
        case (state_reg)
            SCRUB: begin
                write_enable_next = 1'b1;
                write_addr_next   = ptr_reg;
                write_data_next   = '0;
            end
            DONE: begin
                if (scrub_count_reg != COUNT_MAX) begin
                    scrub_count_next = scrub_count_reg + COUNT_W'(1);
                end
            end
            IDLE: begin
                if (client_xfer) begin
                    write_enable_next = 1'b1;
                    write_addr_next   = client.client_wr_addr;
                    write_data_next   = client.client_wr_data;
                end
            end
            default: begin
                write_enable_next = 1'b0;
            end
        endcase
    end

    assign client.client_wr_ready = client_ready;
    assign write_enable           = write_enable_reg;
    assign write_addr             = write_addr_reg;
    assign write_data             = write_data_reg;
    assign busy                   = (state_reg != IDLE);
    assign scrub_done             = (state_reg == DONE);
    assign scrub_count            = scrub_count_reg;

endmodule : regfile_scrub_controller

// File: doc/regfile_scrub_controller.md
REGFILE_SCRUB_CONTROLLER -- requirements
Module: regfile_scrub_controller

Interface
REQ-001 Parameter NUM_REGS, default 16, number of register file entries to scrub.
REQ-002 Parameter ADDR_W, default 4, register address width; SHALL equal clog2(NUM_REGS).
REQ-003 Parameter DATA_W, default 32, register data width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 scrub_req  input  1  request to zero all register file entries, level-sampled per cycle.
REQ-007 client_wr_valid  input  1  client write request.
REQ-008 client_wr_ready  output  1  controller accepts a client write this cycle.
REQ-009 client_wr_addr  input  ADDR_W  client write address.
REQ-010 client_wr_data  input  DATA_W  client write data.
REQ-011 write_enable  output  1  write strobe to the downstream register file.
REQ-012 write_addr  output  ADDR_W  register file write address.
REQ-013 write_data  output  DATA_W  register file write data.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 scrub_done  output  1  one-cycle pulse on scrub completion.
REQ-016 scrub_count  output  8  number of completed scrubs, saturating.

Function
REQ-017 The FSM SHALL have exactly three states: SCRUB, DONE, IDLE.
REQ-018 write_enable, write_addr and write_data SHALL be registered outputs with one cycle of latency from decision to visibility.
REQ-019 In SCRUB, each edge SHALL load write_enable=1, write_addr=ptr, write_data=0 and then increment ptr.
REQ-020 When ptr==NUM_REGS-1 is loaded, the FSM SHALL go to DONE; a scrub is exactly NUM_REGS consecutive writes, addresses ascending from 0.
REQ-021 DONE SHALL last one cycle: scrub_done=1, scrub_count incremented (held at 255), write_enable loaded 0, next state IDLE.
REQ-022 client_wr_ready SHALL equal (state==IDLE), combinationally.
REQ-023 In IDLE, a transfer SHALL occur when client_wr_valid && client_wr_ready; the next edge loads write_enable=1 with the client address and data.
REQ-024 A cycle without a transfer SHALL load write_enable=0.
REQ-025 scrub_req=1 in IDLE SHALL move the FSM to SCRUB at the next edge, with ptr=0.
REQ-026 If a client transfer occurs in the same cycle as scrub_req, the client write SHALL be emitted first and the scrub SHALL follow, overwriting it.
REQ-027 scrub_req in SCRUB or DONE SHALL be ignored; no re-queue occurs.
REQ-028 During SCRUB and DONE, client writes SHALL stall (ready=0); the client holds valid, addr and data until accepted.
REQ-029 The ptr increment SHALL use ADDR_W-bit arithmetic; the terminal compare SHALL use NUM_REGS-1, not wrap.

Reset
REQ-030 Asserting rst SHALL immediately set: state=SCRUB, ptr=0, write_enable=0, write_addr=0, write_data=0, scrub_count=0.
REQ-031 After reset, busy SHALL be 1, client_wr_ready 0 and scrub_done 0, so every release from reset begins a full scrub.
REQ-032 Reset asserted mid-scrub SHALL abandon the scrub; after release it restarts from address 0.

Structure
REQ-033 NUM_REGS, ADDR_W, DATA_W defaults and the state enum SHALL live in a shared regfile package, also used by the register file.
REQ-034 The block SHALL be a single module with no sub-modules; the FSM, pointer and output registers are inline.

Verification
REQ-035 Release reset -> write_enable high for 16 cycles, addresses 0..15, data 0; scrub_done pulses with the address-15 write; ready=1 on the following cycle; scrub_count=1.
REQ-036 IDLE, client write addr 5, data 0xDEADBEEF -> next cycle write_enable=1, write_addr=5, write_data=0xDEADBEEF; one cycle only.
REQ-037 IDLE, scrub_req and client write (addr 3, 0x12345678) in the same cycle -> client write visible at t+1, scrub addresses 0..15 at t+2..t+17, scrub_count increments.
REQ-038 Client valid held during scrub (addr 9, 0xA5A5A5A5) -> ready stays 0 until IDLE; accepted in the first IDLE cycle, written once.
REQ-039 Assert rst when write_addr=7 in SCRUB -> outputs clear immediately; after release the scrub restarts at address 0 and performs 16 writes.
REQ-040 Force 260 scrubs -> scrub_count saturates at 255 and never wraps to 0.
